// File: rtl/instruction_decoder.sv
// RV32I main control decoder: turns an instruction word into datapath control.
// All outputs are registered, so decode results appear one clock after the instruction.
module instruction_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign funct7_b5 = instruction[30];

  logic [3:0] alu_op_d,     alu_op_q;
  logic       reg_write_d,  reg_write_q;
  logic [1:0] alu_src_d,    alu_src_q;
  logic       mem_read_d,   mem_read_q;
  logic       mem_write_d,  mem_write_q;
  logic [1:0] mem_to_reg_d, mem_to_reg_q;
  logic       branch_d,     branch_q;
  logic       jump_d,       jump_q;
  logic       illegal_d,    illegal_q;

  // Shared funct3 ALU map; only R-type may turn 000 into SUB, ADDI ignores funct7.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       f7b5,
                                                 input logic       is_r);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    alu_op_d     = ALU_ADD;
    reg_write_d  = 1'b0;
    alu_src_d    = 2'b00;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 2'b00;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    illegal_d    = 1'b0;
    case (opcode)
      OP_R: begin
        alu_op_d     = alu_from_funct3(funct3, funct7_b5, 1'b1);
        reg_write_d  = 1'b1;
        mem_to_reg_d = 2'b01;
      end
      OP_IMM: begin
        alu_op_d     = alu_from_funct3(funct3, funct7_b5, 1'b0);
        reg_write_d  = 1'b1;
        alu_src_d    = 2'b10;
        mem_to_reg_d = 2'b01;
      end
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 2'b10;
        mem_to_reg_d = 2'b11;
        mem_read_d   = 1'b1;
      end
      OP_STORE: begin
        alu_src_d    = 2'b10;
        mem_write_d  = 1'b1;
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: begin alu_op_d = ALU_SUB;  branch_d = 1'b1; end
          3'b100, 3'b101: begin alu_op_d = ALU_SLT;  branch_d = 1'b1; end
          3'b110, 3'b111: begin alu_op_d = ALU_SLTU; branch_d = 1'b1; end
          default:        illegal_d = 1'b1;
        endcase
      end
      OP_LUI: begin
        reg_write_d  = 1'b1;
      end
      OP_AUIPC: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 2'b11;
        mem_to_reg_d = 2'b01;
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 2'b11;
        mem_to_reg_d = 2'b10;
        jump_d       = 1'b1;
      end
      OP_JALR: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 2'b10;
        mem_to_reg_d = 2'b10;
        jump_d       = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_op_q     <= ALU_ADD;
      reg_write_q  <= 1'b0;
      alu_src_q    <= 2'b00;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 2'b00;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      alu_op_q     <= alu_op_d;
      reg_write_q  <= reg_write_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      illegal_q    <= illegal_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign reg_write  = reg_write_q;
  assign alu_src    = alu_src_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_to_reg = mem_to_reg_q;
  assign branch     = branch_q;
  assign jump       = jump_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: hand-computed decode vectors, one line per step.
module tb_instruction_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [3:0]  alu_op;
  logic        reg_write;
  logic [1:0]  alu_src;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_to_reg;
  logic        branch;
  logic        jump;
  logic        illegal;

  int pass_cnt  = 0;
  int total_cnt = 0;

  instruction_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .branch      (branch),
    .jump        (jump),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as alu_op/reg_write/alu_src/mem_read/mem_write/mem_to_reg/branch/jump/illegal.
  function automatic logic [14:0] pk(input logic [3:0] a, input logic rw, input logic [1:0] src,
                                     input logic mr, input logic mw, input logic [1:0] mtr,
                                     input logic b, input logic j, input logic ill);
    return {a, rw, src, mr, mw, mtr, b, j, ill};
  endfunction

  // Apply one instruction, clock it in, and compare the registered decode.
  task automatic step(input string tag, input logic rst_val, input logic [31:0] instr,
                      input logic [14:0] expected);
    logic [14:0] observed;
    rst_n       = rst_val;
    instruction = instr;
    @(posedge clk);
    #1;
    observed = {alu_op, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, illegal};
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s instr=%08h observed=%015b expected=%015b", tag, instr, observed, expected);
    $display("step %-10s rst_n=%0b instr=%08h out=%015b exp=%015b", tag, rst_val, instr,
             observed, expected);
  endtask

  initial begin
    rst_n       = 1'b1;
    instruction = 32'h0;
    #2;
    step("reset",    1'b0, 32'h00208033, pk(4'd0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0));
    step("add",      1'b1, 32'h00208033, pk(4'd0, 1, 2'b00, 0, 0, 2'b01, 0, 0, 0));
    step("sub",      1'b1, 32'h40208033, pk(4'd1, 1, 2'b00, 0, 0, 2'b01, 0, 0, 0));
    step("and",      1'b1, 32'h00207033, pk(4'd2, 1, 2'b00, 0, 0, 2'b01, 0, 0, 0));
    step("sra",      1'b1, 32'h4020D033, pk(4'd7, 1, 2'b00, 0, 0, 2'b01, 0, 0, 0));
    step("addi",     1'b1, 32'h00208093, pk(4'd0, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0));
    step("addi_f7",  1'b1, 32'h40208093, pk(4'd0, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0));
    step("slli",     1'b1, 32'h00209093, pk(4'd5, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0));
    step("slti",     1'b1, 32'h0020A093, pk(4'd8, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0));
    step("sltiu",    1'b1, 32'h0020B093, pk(4'd9, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0));
    step("xori",     1'b1, 32'h0020C093, pk(4'd4, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0));
    step("srli",     1'b1, 32'h0020D093, pk(4'd6, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0));
    step("srai",     1'b1, 32'h4020D093, pk(4'd7, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0));
    step("ori",      1'b1, 32'h0020E093, pk(4'd3, 1, 2'b10, 0, 0, 2'b01, 0, 0, 0));
    step("lw",       1'b1, 32'h00202083, pk(4'd0, 1, 2'b10, 1, 0, 2'b11, 0, 0, 0));
    step("sw",       1'b1, 32'h00202023, pk(4'd0, 0, 2'b10, 0, 1, 2'b00, 0, 0, 0));
    step("beq",      1'b1, 32'h00208063, pk(4'd1, 0, 2'b00, 0, 0, 2'b00, 1, 0, 0));
    step("blt",      1'b1, 32'h0020C063, pk(4'd8, 0, 2'b00, 0, 0, 2'b00, 1, 0, 0));
    step("bltu",     1'b1, 32'h0020E063, pk(4'd9, 0, 2'b00, 0, 0, 2'b00, 1, 0, 0));
    step("br_f3_010",1'b1, 32'h0020A063, pk(4'd0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1));
    step("jal",      1'b1, 32'h004000EF, pk(4'd0, 1, 2'b11, 0, 0, 2'b10, 0, 1, 0));
    step("jalr",     1'b1, 32'h000080E7, pk(4'd0, 1, 2'b10, 0, 0, 2'b10, 0, 1, 0));
    step("lui",      1'b1, 32'h123450B7, pk(4'd0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0));
    step("auipc",    1'b1, 32'h12345097, pk(4'd0, 1, 2'b11, 0, 0, 2'b01, 0, 0, 0));
    step("ill_7f",   1'b1, 32'h0000007F, pk(4'd0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1));
    step("ill_zero", 1'b1, 32'h00000000, pk(4'd0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1));
    // Back-to-back changes, then a mid-stream reset on a load.
    step("b2b_sub",  1'b1, 32'h40208033, pk(4'd1, 1, 2'b00, 0, 0, 2'b01, 0, 0, 0));
    step("b2b_ill",  1'b1, 32'h0000007F, pk(4'd0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1));
    step("b2b_sw",   1'b1, 32'h00202023, pk(4'd0, 0, 2'b10, 0, 1, 2'b00, 0, 0, 0));
    step("rst_lw",   1'b0, 32'h00202083, pk(4'd0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0));
    step("post_lw",  1'b1, 32'h00202083, pk(4'd0, 1, 2'b10, 1, 0, 2'b11, 0, 0, 0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
